reg_dump_reader: RTL and testbench



---
 rtl/lc3_pkg.sv | 17 +
 rtl/reg_dump_reader.sv | 84 ++++++++
 tb/tb_reg_dump_reader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 types used by the register-file side blocks.
// Includes the register dump FSM encoding.
package lc3_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    localparam int LC3_NUM_REGS = 8;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks R0..NUM_REGS-1 through the register file read port.
// Streams each word, tagged with its index, over a valid/ready interface.
module reg_dump_reader
    import lc3_pkg::*;
#(
    parameter int NUM_REGS = LC3_NUM_REGS,
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 3
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_e      state;
    dump_state_e      state_nxt;
    logic [IDX_W-1:0] idx;
    logic             hs;

    assign hs = out_valid && out_ready;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = SEND;
            SEND:    if (hs) state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort outranks both start and a same-cycle handshake
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        rd_addr = (state == IDLE) ? '0 : idx;
    end

    // Registered outputs follow the state being entered, so they line up with it.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= (state_nxt == SEND);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            if (state == IDLE && state_nxt == FETCH) begin
                idx <= '0;
            end
            if (state == SEND && state_nxt == FETCH) begin
                idx <= idx + 1'b1;
            end
            if (state == FETCH && state_nxt == SEND) begin
                out_data  <= rd_data;
                out_index <= idx;
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader paired with a behavioural LC-3 register file.
// Covers ready stalls, abort, held start, write/fetch ordering and async reset.
module tb_reg_dump_reader;
    import lc3_pkg::*;

    logic     Clk = 1'b0;
    logic     reset_n;
    logic     start;
    logic     abort;
    reg_idx_t rd_addr;
    word_t    rd_data;
    logic     out_valid;
    logic     out_ready;
    word_t    out_data;
    reg_idx_t out_index;
    logic     busy;
    logic     done;

    word_t    regs [8];
    logic     we;
    reg_idx_t wa;
    word_t    wd;

    word_t    exp_data [8];
    int       tests = 0;
    int       fails = 0;
    int       cyc = 0;
    int       wr_at = -1;
    reg_idx_t wr_idx = '0;
    word_t    wr_val = '0;
    bit       tog = 1'b0;

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) begin
        if (we) regs[wa] <= wd;
    end
    assign rd_data = regs[rd_addr];

    reg_dump_reader #(.NUM_REGS(8), .DATA_W(16), .IDX_W(3)) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; drive the scheduled LD_REG write and optional ready toggle.
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        we = (cyc == wr_at);
        if (we) begin
            wa = wr_idx;
            wd = wr_val;
        end
        if (tog) out_ready = ~out_ready;
    endtask

    task automatic wr(input int i, input word_t v);
        we = 1'b1;
        wa = reg_idx_t'(i);
        wd = v;
        tick();
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"},  {16'd0, out_data},  32'd0);
        chk({tag, "_index"}, {29'd0, out_index}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_done"},  {31'd0, done},      32'd0);
        chk({tag, "_rdaddr"}, {29'd0, rd_addr},  32'd0);
    endtask

    // Entered in the FETCH cycle of R0; leaves in the IDLE cycle after DONE.
    task automatic do_dump(input string tag);
        int guard;
        chk({tag, "_f0_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_f0_busy"},  {31'd0, busy},      32'd1);
        chk({tag, "_f0_rdaddr"}, {29'd0, rd_addr},  32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            guard = 0;
            while (!out_ready && guard < 4) begin
                chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_stall_data"},  {16'd0, out_data},  {16'd0, exp_data[i]});
                chk({tag, "_stall_index"}, {29'd0, out_index}, i);
                tick();
                guard++;
            end
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_data"},  {16'd0, out_data},  {16'd0, exp_data[i]});
            chk({tag, "_index"}, {29'd0, out_index}, i);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            tick();
            if (i < 7) begin
                chk({tag, "_fetch_valid"},  {31'd0, out_valid}, 32'd0);
                chk({tag, "_fetch_rdaddr"}, {29'd0, rd_addr},   i + 1);
            end
        end
        chk({tag, "_done_pulse"}, {31'd0, done},      32'd1);
        chk({tag, "_done_busy"},  {31'd0, busy},      32'd1);
        chk({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_end_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        we = 1'b0;
        wa = '0;
        wd = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk_idle_outputs("reset");
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            wr(i, word_t'(16'h1000 + i));
            exp_data[i] = word_t'(16'h1000 + i);
        end
        chk_idle_outputs("idle_after_preload");

        // Back-to-back words with the consumer always ready
        kick();
        do_dump("ready_hi");

        // Consumer alternates ready every cycle
        tog = 1'b1;
        kick();
        do_dump("ready_tog");
        tog = 1'b0;
        out_ready = 1'b1;

        // Abort in SEND of R3 with a same-cycle handshake
        kick();
        for (int k = 0; k < 7; k++) tick();
        chk("abort_pre_index", {29'd0, out_index}, 32'd3);
        chk("abort_pre_valid", {31'd0, out_valid}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy",  {31'd0, busy},      32'd0);
        chk("abort_done",  {31'd0, done},      32'd0);
        tick();
        chk("abort_done_late", {31'd0, done}, 32'd0);
        chk("abort_busy_late", {31'd0, busy}, 32'd0);
        kick();
        do_dump("after_abort");

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_vs_start_busy", {31'd0, busy}, 32'd0);

        // start held through a dump: one dump, then a fresh one from IDLE
        start = 1'b1;
        tick();
        cyc = 0;
        do_dump("held_start");
        tick();
        chk("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc = 0;
        do_dump("held_second");

        // Write to R5 lands on the edge entering FETCH of R5: new value seen
        kick();
        wr_at = 9;
        wr_idx = 3'd5;
        wr_val = 16'hBEEF;
        exp_data[5] = 16'hBEEF;
        do_dump("wr_before");
        wr_at = -1;
        wr(5, 16'h1005);

        // Write to R5 lands on the FETCH-of-R5 capture edge: old value seen
        kick();
        wr_at = 10;
        exp_data[5] = 16'h1005;
        do_dump("wr_same");
        wr_at = -1;
        wr(5, 16'h1005);

        // Asynchronous reset while in SEND of R4
        kick();
        for (int k = 0; k < 9; k++) tick();
        chk("rst_pre_index", {29'd0, out_index}, 32'd4);
        chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy",  {31'd0, busy},      32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        kick();
        do_dump("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
